platform_onchip_memory_burst_adapter: RTL and testbench

//  Avalon-MM burst slave placed directly upstream of the on-chip SRAM (single-port, 32-bit, 8192 words).

---
 rtl/platform_onchip_memory_burst_adapter_pkg.sv | 14 +
 rtl/platform_onchip_memory_burst_adapter_if.sv | 41 ++++
 rtl/platform_onchip_memory_burst_adapter_addr_gen.sv | 38 +++
 rtl/platform_onchip_memory_burst_adapter.sv | 138 +++++++++++++
 tb/tb_platform_onchip_memory_burst_adapter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/platform_onchip_memory_burst_adapter_pkg.sv
// Shared types and default widths for the on-chip SRAM burst adapter.
package platform_onchip_pkg;

  localparam int ADDR_W_DEF  = 13;
  localparam int DATA_W_DEF  = 32;
  localparam int BURST_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_e;

endpackage

// File: rtl/platform_onchip_memory_burst_adapter_if.sv
// Avalon-MM burst slave side plus SRAM master side of the adapter, bundled as one interface.
interface platform_onchip_memory_burst_adapter_if
  import platform_onchip_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BURST_W = BURST_W_DEF
);
  localparam int BE_W = DATA_W / 8;

  logic [ADDR_W-1:0]  s_address;
  logic [BURST_W-1:0] s_burstcount;
  logic               s_read;
  logic               s_write;
  logic [DATA_W-1:0]  s_writedata;
  logic [BE_W-1:0]    s_byteenable;
  logic               s_waitrequest;
  logic [DATA_W-1:0]  s_readdata;
  logic               s_readdatavalid;

  logic [ADDR_W-1:0]  m_address;
  logic [BE_W-1:0]    m_byteenable;
  logic               m_chipselect;
  logic               m_write;
  logic [DATA_W-1:0]  m_writedata;
  logic               m_clken;
  logic [DATA_W-1:0]  m_readdata;

  modport slave (
    input  s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable, m_readdata,
    output s_waitrequest, s_readdata, s_readdatavalid,
           m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );

  modport master (
    output s_address, s_burstcount, s_read, s_write, s_writedata, s_byteenable, m_readdata,
    input  s_waitrequest, s_readdata, s_readdatavalid,
           m_address, m_byteenable, m_chipselect, m_write, m_writedata, m_clken
  );

endinterface

// File: rtl/platform_onchip_memory_burst_adapter_addr_gen.sv
// Loadable word-address counter and remaining-beats counter for one burst.
module platform_burst_addr_gen
  import platform_onchip_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [ADDR_W-1:0]  i_load_addr,
  input  logic [BURST_W-1:0] i_load_cnt,
  input  logic               i_step,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_last
);

  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_remaining;

  // Address increment wraps naturally at 2**ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_load_addr;
      r_remaining <= i_load_cnt;
    end else if (i_step) begin
      r_addr      <= r_addr + ADDR_W'(1);
      r_remaining <= r_remaining - BURST_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == BURST_W'(1));

endmodule

// File: rtl/platform_onchip_memory_burst_adapter.sv
// Splits Avalon-MM incrementing bursts into single-word SRAM accesses with a 1-cycle read return.
module platform_onchip_memory_burst_adapter
  import platform_onchip_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic clk,
  input  logic reset,
  platform_onchip_memory_burst_adapter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  function automatic logic [BURST_W-1:0] eff_burst(input logic [BURST_W-1:0] bc);
    return (bc == '0) ? BURST_W'(1) : bc;
  endfunction

  state_e             r_state;
  logic               r_waitrequest;
  logic               r_rd_pend;

  logic [BURST_W-1:0] w_burst;
  logic               w_multi;
  logic               w_rd_issue;
  logic               w_wr_issue;
  logic               w_load;
  logic               w_step;
  logic [ADDR_W-1:0]  w_addr;
  logic [BE_W-1:0]    w_be;
  logic [ADDR_W-1:0]  w_gen_addr;
  logic               w_gen_last;

  assign w_burst = eff_burst(bus.s_burstcount);
  assign w_multi = (w_burst > BURST_W'(1));

  platform_burst_addr_gen #(
    .ADDR_W  (ADDR_W),
    .BURST_W (BURST_W)
  ) u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_addr (bus.s_address + ADDR_W'(1)),
    .i_load_cnt  (w_burst - BURST_W'(1)),
    .i_step      (w_step),
    .o_addr      (w_gen_addr),
    .o_last      (w_gen_last)
  );

  // In IDLE a simultaneous read and write resolves to the read; the write is left unaccepted.
  always_comb begin
    w_rd_issue = 1'b0;
    w_wr_issue = 1'b0;
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_addr     = bus.s_address;
    w_be       = '1;
    unique case (r_state)
      IDLE: begin
        if (bus.s_read) begin
          w_rd_issue = 1'b1;
        end else if (bus.s_write) begin
          w_wr_issue = 1'b1;
          w_be       = bus.s_byteenable;
        end
        w_load = (bus.s_read | bus.s_write) & w_multi;
      end
      RD_BURST: begin
        w_addr     = w_gen_addr;
        w_rd_issue = 1'b1;
        w_step     = 1'b1;
      end
      WR_BURST: begin
        w_addr = w_gen_addr;
        if (bus.s_write) begin
          w_wr_issue = 1'b1;
          w_be       = bus.s_byteenable;
          w_step     = 1'b1;
        end
      end
      default: ;
    endcase
    // No SRAM access may start while reset is being sampled.
    if (reset) begin
      w_rd_issue = 1'b0;
      w_wr_issue = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_waitrequest <= 1'b0;
      r_rd_pend     <= 1'b0;
    end else begin
      r_rd_pend <= w_rd_issue;
      unique case (r_state)
        IDLE: begin
          if (w_rd_issue && w_multi) begin
            r_state       <= RD_BURST;
            r_waitrequest <= 1'b1;
          end else if (w_wr_issue && w_multi) begin
            r_state <= WR_BURST;
          end
        end
        RD_BURST: begin
          if (w_gen_last) begin
            r_state       <= IDLE;
            r_waitrequest <= 1'b0;
          end
        end
        WR_BURST: begin
          if (w_wr_issue && w_gen_last) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_waitrequest <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_waitrequest   = r_waitrequest;
  assign bus.s_readdatavalid = r_rd_pend;
  assign bus.s_readdata      = bus.m_readdata;

  assign bus.m_address    = w_addr;
  assign bus.m_byteenable = w_be;
  assign bus.m_chipselect = w_rd_issue | w_wr_issue;
  assign bus.m_write      = w_wr_issue;
  assign bus.m_writedata  = bus.s_writedata;
  assign bus.m_clken      = 1'b1;

endmodule

// File: tb/tb_platform_onchip_memory_burst_adapter.sv
// Directed bench for the burst adapter with a behavioural single-port SRAM behind it.
module tb_platform_onchip_memory_burst_adapter;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic        pre_we   = 1'b0;
  logic [12:0] pre_addr = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [8192];
  logic [31:0] sram_q;

  platform_onchip_memory_burst_adapter_if #(.ADDR_W(13), .DATA_W(32), .BURST_W(4)) bus ();

  platform_onchip_memory_burst_adapter #(.ADDR_W(13), .DATA_W(32), .BURST_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.m_chipselect && bus.m_write) begin
      for (int b = 0; b < 4; b++)
        if (bus.m_byteenable[b]) mem[bus.m_address][8*b +: 8] <= bus.m_writedata[8*b +: 8];
    end
    if (bus.m_chipselect && !bus.m_write) sram_q <= mem[bus.m_address];
  end

  assign bus.m_readdata = sram_q;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic preload(input logic [12:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  logic [12:0] t2_addr [4];
  logic [31:0] t2_data [4];
  int wcnt;
  int vcnt;

  initial begin
    bus.s_address    = '0;
    bus.s_burstcount = 4'd1;
    bus.s_read       = 1'b0;
    bus.s_write      = 1'b0;
    bus.s_writedata  = '0;
    bus.s_byteenable = 4'hF;
    t2_addr = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    t2_data = '{32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_wait",  bus.s_waitrequest,   0);
    check_eq("rst_rdv",   bus.s_readdatavalid, 0);
    check_eq("rst_cs",    bus.m_chipselect,    0);
    check_eq("rst_wr",    bus.m_write,         0);
    check_eq("rst_state", dut.r_state,         0);
    check_eq("rst_clken", bus.m_clken,         1);
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: single read
    preload(13'h010, 32'hDEADBEEF);
    bus.s_address = 13'h010; bus.s_burstcount = 4'd1; bus.s_read = 1'b1;
    @(negedge clk);
    check_eq("t1_addr", bus.m_address,      13'h010);
    check_eq("t1_cs",   bus.m_chipselect,   1);
    check_eq("t1_be",   bus.m_byteenable,   4'hF);
    check_eq("t1_wait", bus.s_waitrequest,  0);
    check_eq("t1_rdv0", bus.s_readdatavalid, 0);
    cyc(); bus.s_read = 1'b0;
    @(negedge clk);
    check_eq("t1_rdv",   bus.s_readdatavalid, 1);
    check_eq("t1_data",  bus.s_readdata,      32'hDEADBEEF);
    check_eq("t1_wait1", bus.s_waitrequest,   0);
    cyc();
    @(negedge clk);
    check_eq("t1_rdv_end", bus.s_readdatavalid, 0);
    cyc();

    // 2: read burst of 4 wrapping at the top of memory
    for (int i = 0; i < 4; i++) preload(t2_addr[i], t2_data[i]);
    bus.s_address = 13'h1FFE; bus.s_burstcount = 4'd4; bus.s_read = 1'b1;
    wcnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.s_waitrequest) wcnt++;
      if (k < 4) check_eq("t2_addr", bus.m_address, t2_addr[k]);
      else       check_eq("t2_cs_end", bus.m_chipselect, 0);
      check_eq("t2_rdv", bus.s_readdatavalid, (k >= 1) ? 1 : 0);
      if (k >= 1) check_eq("t2_data", bus.s_readdata, t2_data[k-1]);
      cyc(); bus.s_read = 1'b0;
    end
    check_eq("t2_waitcycles", wcnt, 3);

    // 3: write burst with a 2-cycle gap and a partial byteenable
    preload(13'h022, 32'hCAFE1234);
    vcnt = 0;
    bus.s_address = 13'h020; bus.s_burstcount = 4'd4; bus.s_write = 1'b1;
    bus.s_writedata = 32'h11111111; bus.s_byteenable = 4'hF;
    @(negedge clk);
    check_eq("t3_addr0", bus.m_address, 13'h020);
    check_eq("t3_wr0",   bus.m_write,   1);
    cyc(); bus.s_writedata = 32'h22222222;
    @(negedge clk);
    check_eq("t3_addr1", bus.m_address,     13'h021);
    check_eq("t3_wait1", bus.s_waitrequest, 0);
    for (int g = 0; g < 2; g++) begin
      cyc(); bus.s_write = 1'b0;
      @(negedge clk);
      check_eq("t3_gap_cs", bus.m_chipselect, 0);
      if (bus.s_readdatavalid) vcnt++;
    end
    cyc(); bus.s_write = 1'b1; bus.s_writedata = 32'h00005678; bus.s_byteenable = 4'h3;
    @(negedge clk);
    check_eq("t3_addr2", bus.m_address,    13'h022);
    check_eq("t3_be2",   bus.m_byteenable, 4'h3);
    cyc(); bus.s_writedata = 32'h44444444; bus.s_byteenable = 4'hF;
    @(negedge clk);
    check_eq("t3_addr3", bus.m_address, 13'h023);
    if (bus.s_readdatavalid) vcnt++;
    cyc(); bus.s_write = 1'b0;
    @(negedge clk);
    check_eq("t3_state", dut.r_state, 0);
    check_eq("t3_novalid", vcnt, 0);
    check_eq("t3_mem20", mem[13'h020], 32'h11111111);
    check_eq("t3_mem21", mem[13'h021], 32'h22222222);
    check_eq("t3_mem22", mem[13'h022], 32'hCAFE5678);
    check_eq("t3_mem23", mem[13'h023], 32'h44444444);
    cyc();

    // 4: simultaneous read and write in IDLE
    preload(13'h030, 32'h11112222);
    bus.s_address = 13'h030; bus.s_burstcount = 4'd1;
    bus.s_read = 1'b1; bus.s_write = 1'b1; bus.s_writedata = 32'h99999999;
    @(negedge clk);
    check_eq("t4_nowr", bus.m_write,      0);
    check_eq("t4_cs",   bus.m_chipselect, 1);
    cyc(); bus.s_read = 1'b0;
    @(negedge clk);
    check_eq("t4_mem_kept", mem[13'h030],       32'h11112222);
    check_eq("t4_rdv",      bus.s_readdatavalid, 1);
    check_eq("t4_data",     bus.s_readdata,      32'h11112222);
    check_eq("t4_wr",       bus.m_write,         1);
    cyc(); bus.s_write = 1'b0;
    @(negedge clk);
    check_eq("t4_mem_new", mem[13'h030], 32'h99999999);
    cyc();

    // 5: reset on the 2nd cycle of an 8-word read
    for (int i = 0; i < 8; i++) preload(13'h040 + 13'(i), 32'h40400000 + i);
    bus.s_address = 13'h040; bus.s_burstcount = 4'd8; bus.s_read = 1'b1;
    @(negedge clk);
    check_eq("t5_addr0", bus.m_address, 13'h040);
    cyc(); bus.s_read = 1'b0; reset = 1'b1;
    @(negedge clk);
    check_eq("t5_rdv_pre", bus.s_readdatavalid, 1);
    cyc(); reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("t5_rdv_off", bus.s_readdatavalid, 0);
      check_eq("t5_cs_off",  bus.m_chipselect,    0);
      cyc();
    end
    check_eq("t5_state", dut.r_state,               0);
    check_eq("t5_rem",   dut.u_addr_gen.r_remaining, 0);
    check_eq("t5_wait",  bus.s_waitrequest,          0);
    bus.s_address = 13'h044; bus.s_burstcount = 4'd2; bus.s_read = 1'b1;
    @(negedge clk);
    check_eq("t5_new_addr", bus.m_address, 13'h044);
    cyc(); bus.s_read = 1'b0;
    @(negedge clk);
    check_eq("t5_new_d0",  bus.s_readdata,      32'h40400004);
    check_eq("t5_new_v0",  bus.s_readdatavalid, 1);
    cyc();
    @(negedge clk);
    check_eq("t5_new_d1",  bus.s_readdata,      32'h40400005);
    check_eq("t5_new_v1",  bus.s_readdatavalid, 1);
    cyc();
    @(negedge clk);
    check_eq("t5_new_end", bus.s_readdatavalid, 0);
    cyc();

    // 6: burstcount 0 read, then a back-to-back read on the valid cycle
    preload(13'h005, 32'h55555555);
    bus.s_address = 13'h005; bus.s_burstcount = 4'd0; bus.s_read = 1'b1;
    @(negedge clk);
    check_eq("t6_addr", bus.m_address,     13'h005);
    check_eq("t6_wait", bus.s_waitrequest, 0);
    cyc(); bus.s_address = 13'h010; bus.s_burstcount = 4'd1;
    @(negedge clk);
    check_eq("t6_rdv",   bus.s_readdatavalid, 1);
    check_eq("t6_data",  bus.s_readdata,      32'h55555555);
    check_eq("t6_wait2", bus.s_waitrequest,   0);
    check_eq("t6_b2b",   bus.m_address,       13'h010);
    check_eq("t6_b2bcs", bus.m_chipselect,    1);
    cyc(); bus.s_read = 1'b0;
    @(negedge clk);
    check_eq("t6_rdv2",  bus.s_readdatavalid, 1);
    check_eq("t6_data2", bus.s_readdata,      32'hDEADBEEF);
    cyc();
    @(negedge clk);
    check_eq("t6_end", bus.s_readdatavalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
